// File: rtl/multicycle_alu_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls, ALU op select,
// illegal-instruction flag and a retired-instruction counter.
module multicycle_alu_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero_flag,
  output logic [1:0]           alu_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 illegal_op,
  output logic [3:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t         state_r, next_s;
  logic [1:0]     sel_r, funct_sel_s;
  logic           funct_ok_s, done_s, latch_sel_s;

  // R-type function field to ALU select mapping
  always_comb begin
    funct_sel_s = 2'b00;
    funct_ok_s  = 1'b1;
    case (funct)
      6'h20:   funct_sel_s = 2'b00;
      6'h22:   funct_sel_s = 2'b01;
      6'h24:   funct_sel_s = 2'b10;
      6'h25:   funct_sel_s = 2'b11;
      default: funct_ok_s  = 1'b0;
    endcase
  end

  // Next-state and Moore output decode (pc_write in BRANCH, illegal_op in DECODE excepted)
  always_comb begin
    next_s      = S_IDLE;
    done_s      = 1'b0;
    latch_sel_s = 1'b0;
    alu_sel     = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_write    = 1'b0;
    pc_source   = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal_op  = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        next_s    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'h23, 6'h2B: next_s = S_MEM_ADDR;
          6'h04:        next_s = S_BRANCH;
          6'h02:        next_s = S_JUMP;
          6'h08:        next_s = S_ADDI_EXEC;
          6'h00: begin
            if (funct_ok_s) begin
              next_s      = S_EXECUTE;
              latch_sel_s = 1'b1;
            end else begin
              next_s      = S_FETCH;
              illegal_op  = 1'b1;
            end
          end
          default: begin
            next_s     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == 6'h2B) begin
          next_s = S_MEM_WRITE;
        end else begin
          next_s = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        next_s   = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done_s     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done_s    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_sel   = sel_r;
        next_s    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        done_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = 2'b01;
        pc_source = 2'b01;
        pc_write  = zero_flag;
        done_s    = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        done_s    = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next_s    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        done_s    = 1'b1;
      end
      default: begin
        // IDLE and the unused codes share the wait-for-run behaviour
        if (run) begin
          next_s = S_FETCH;
        end else begin
          next_s = S_IDLE;
        end
      end
    endcase
    if (done_s) begin
      if (run) begin
        next_s = S_FETCH;
      end else begin
        next_s = S_IDLE;
      end
    end else begin
      next_s = next_s;
    end
  end

  // State, latched ALU select and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      sel_r       <= 2'b00;
      instr_count <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_s;
      if (latch_sel_s) begin
        sel_r <= funct_sel_s;
      end
      if (done_s) begin
        instr_count <= instr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state_dbg = state_r;

endmodule

// File: tb/tb_multicycle_alu_control.sv
// Random-instruction bench: a path-per-instruction model predicts state, outputs
// and retired count every cycle; a single negedge process compares.
module tb_multicycle_alu_control;

  logic        clk = 1'b0;
  logic        rst_n, run, zero_flag;
  logic [5:0]  opcode, funct;
  logic [1:0]  alu_sel, alu_src_b, pc_source;
  logic        alu_src_a, pc_write, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0]  state_dbg;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_state = 0;
  int exp_count = 0;
  int zf_mode = 2;
  bit chk_en = 1'b0;

  multicycle_alu_control #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .alu_sel(alu_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25};
    return op inside {6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  endfunction

  function automatic logic [1:0] sel_of(input logic [5:0] fn);
    case (fn)
      6'h22:   return 2'b01;
      6'h24:   return 2'b10;
      6'h25:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // {alu_sel, src_a, src_b, pc_write, pc_source, iord, mem_read, mem_write,
  //  ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, state}
  function automatic logic [19:0] expect_v(input int s, input logic zf,
                                           input logic [5:0] op, input logic [5:0] fn);
    logic [1:0] sel, sb, ps;
    logic sa, pw, io, mr, mw, iw, rd, m2r, rw, ill;
    logic [3:0] st;
    {sel, sb, ps} = 6'd0;
    {sa, pw, io, mr, mw, iw, rd, m2r, rw, ill} = 10'd0;
    st = 4'(s);
    case (s)
      1:  begin mr = 1'b1; iw = 1'b1; pw = 1'b1; sb = 2'b01; end
      2:  begin sb = 2'b11; ill = !legal(op, fn); end
      3:  begin sa = 1'b1; sb = 2'b10; end
      4:  begin mr = 1'b1; io = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mw = 1'b1; io = 1'b1; end
      7:  begin sa = 1'b1; sel = sel_of(fn); end
      8:  begin rw = 1'b1; rd = 1'b1; end
      9:  begin sa = 1'b1; sel = 2'b01; ps = 2'b01; pw = zf; end
      10: begin ps = 2'b10; pw = 1'b1; end
      11: begin sa = 1'b1; sb = 2'b10; end
      12: begin rw = 1'b1; end
      default: st = 4'd0;
    endcase
    return {sel, sa, sb, pw, ps, io, mr, mw, iw, rd, m2r, rw, ill, st};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [19:0] got, want;
    if (chk_en) begin
      got  = {alu_sel, alu_src_a, alu_src_b, pc_write, pc_source, iord, mem_read,
              mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, state_dbg};
      want = expect_v(exp_state, zero_flag, opcode, funct);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t got=%05h want=%05h (state %0d)", $time, got, want, exp_state);
      end
      checks++;
      if (instr_count !== 32'(exp_count)) begin
        errors++;
        $display("FAIL instr_count t=%0t got=%0d want=%0d", $time, instr_count, exp_count);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int s);
    @(posedge clk);
    #1;
    exp_state = s;
    if (zf_mode == 2) zero_flag = 1'($urandom_range(0, 1));
    else zero_flag = 1'(zf_mode);
  endtask

  // Issue one instruction; DUT is in FETCH on entry and on return
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input bit run_end, input int abort_s);
    int path[$];
    bit ok;
    opcode = op;
    funct  = fn;
    run    = 1'($urandom_range(0, 1));
    ok     = legal(op, fn);
    case (op)
      6'h23:   path = '{2, 3, 4, 5};
      6'h2B:   path = '{2, 3, 6};
      6'h00:   if (ok) path = '{2, 7, 8}; else path = '{2};
      6'h04:   path = '{2, 9};
      6'h02:   path = '{2, 10};
      6'h08:   path = '{2, 11, 12};
      default: path = '{2};
    endcase
    foreach (path[i]) begin
      tick(path[i]);
      if (path[i] == abort_s) begin
        rst_n = 1'b0;
        tick(0);
        exp_count = 0;
        rst_n = 1'b1;
        run = 1'b1;
        tick(1);
        return;
      end
      if (ok && i == path.size() - 1) run = run_end;
      else run = 1'($urandom_range(0, 1));
    end
    if (ok) begin
      if (run_end) begin
        tick(1);
        exp_count++;
      end else begin
        tick(0);
        exp_count++;
        run = 1'b1;
        tick(1);
      end
    end else begin
      tick(1);
    end
  endtask

  task automatic random_instr();
    logic [5:0] op, fn;
    int k;
    k  = $urandom_range(0, 7);
    fn = 6'($urandom_range(0, 63));
    case (k)
      0: op = 6'h23;
      1: op = 6'h2B;
      2: begin op = 6'h00; fn = sel_of(6'h00) == 2'b00 ? 6'h20 : 6'h20;
           case ($urandom_range(0, 3))
             0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; default: fn = 6'h25;
           endcase
         end
      3: op = 6'h04;
      4: op = 6'h02;
      5: op = 6'h08;
      6: begin
           op = 6'h00;
           while (legal(op, fn)) fn = 6'($urandom_range(0, 63));
         end
      default: begin
           op = 6'($urandom_range(0, 63));
           while (op == 6'h00 || legal(op, fn)) op = 6'($urandom_range(0, 63));
         end
    endcase
    do_instr(op, fn, $urandom_range(0, 3) != 0, -1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; zero_flag = 1'b0; opcode = 6'h00; funct = 6'h00;
    tick(0);
    chk_en = 1'b1;
    tick(0);
    pin("reset_state", 32'(state_dbg), 32'd0);
    pin("reset_count", instr_count, 32'd0);
    pin("reset_srcb", 32'(alu_src_b), 32'd0);
    rst_n = 1'b1; run = 1'b1;
    tick(1);
    pin("fetch_srcb", 32'(alu_src_b), 32'd1);
    pin("fetch_irw", 32'(ir_write), 32'd1);
    do_instr(6'h23, 6'h00, 1'b1, -1);
    pin("lw_count", instr_count, 32'd1);
    do_instr(6'h00, 6'h22, 1'b1, -1);
    do_instr(6'h00, 6'h24, 1'b1, -1);
    do_instr(6'h00, 6'h25, 1'b1, -1);
    do_instr(6'h00, 6'h20, 1'b1, -1);
    pin("rtype_count", instr_count, 32'd5);
    zf_mode = 1; do_instr(6'h04, 6'h00, 1'b1, -1);
    zf_mode = 0; do_instr(6'h04, 6'h00, 1'b1, -1);
    zf_mode = 2;
    do_instr(6'h3F, 6'h00, 1'b1, -1);
    do_instr(6'h00, 6'h00, 1'b1, -1);
    pin("illegal_count", instr_count, 32'd7);
    do_instr(6'h00, 6'h20, 1'b0, -1);
    pin("stop_count", instr_count, 32'd8);
    do_instr(6'h23, 6'h00, 1'b1, 4);
    pin("abort_count", instr_count, 32'd0);
    for (int n = 0; n < 300; n++) random_instr();
    do_instr(6'h2B, 6'h00, 1'b1, -1);
    pin("final_count_nonzero", 32'(instr_count != 32'd0), 32'd1);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu_control.md
Name: multicycle_alu_control

Overview:
- Multicycle MIPS control FSM that drives the datapath and issues operations to the 32-bit ALU over that ALU's 2-bit `sel` interface (00 add, 01 sub, 10 AND, 11 OR).
- Consumes the ALU `zeroFlag` to resolve `beq`.
- Sits between the instruction register and the datapath muxes/regfile/memory.
- Supported instructions: R-type add/sub/and/or, `lw`, `sw`, `beq`, `j`, `addi`.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  enable; sampled in IDLE and at instruction completion
- opcode  in  6  IR[31:26], stable from DECODE until FETCH
- funct  in  6  IR[5:0]
- zero_flag  in  1  ALU zeroFlag
- alu_sel  out  2  to ALU sel
- alu_src_a  out  1  ALU A source: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B source: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_write  out  1  PC load
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  regfile write enable
- illegal_op  out  1  one-cycle flag for an unsupported instruction
- state_dbg  out  4  current state code
- instr_count  out  CNT_WIDTH  retired-instruction counter

Behaviour:
- Reset: on any rising edge with rst_n=0:
  - state <= IDLE, instr_count <= 0, funct-derived sel register <= 00.
  - All outputs 0 from that edge on.
  - Applies mid-instruction too; no completion is recorded.
- Outputs are decoded from the state register (Moore). Exceptions: pc_write in BRANCH follows zero_flag; illegal_op in DECODE is decoded from opcode/funct.
- Any output not listed for a state is 0.
- States (code), outputs asserted, next state:
  - IDLE(0): none. -> FETCH if run, else IDLE.
  - FETCH(1): mem_read, ir_write, pc_write; iord=0, alu_src_a=0, alu_src_b=01, alu_sel=00, pc_source=00. -> DECODE.
  - DECODE(2): alu_src_a=0, alu_src_b=11, alu_sel=00. Next state by opcode:
    - 0x23/0x2B -> MEM_ADDR
    - 0x00 -> EXECUTE
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - On entry to EXECUTE, latch funct: 0x20 -> 00, 0x22 -> 01, 0x24 -> 10, 0x25 -> 11.
    - Any other opcode, or opcode 0x00 with any other funct: illegal_op=1 this cycle, -> FETCH, not counted.
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_sel=00. -> MEM_READ (0x23) / MEM_WRITE (0x2B).
  - MEM_READ(4): mem_read, iord=1. -> MEM_WB.
  - MEM_WB(5): reg_write, mem_to_reg=1, reg_dst=0. Completion.
  - MEM_WRITE(6): mem_write, iord=1. Completion.
  - EXECUTE(7): alu_src_a=1, alu_src_b=00, alu_sel=latched value. -> R_WB.
  - R_WB(8): reg_write, reg_dst=1, mem_to_reg=0. Completion.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_sel=01, pc_source=01, pc_write=zero_flag. Completion.
  - JUMP(10): pc_source=10, pc_write. Completion.
  - ADDI_EXEC(11): alu_src_a=1, alu_src_b=10, alu_sel=00. -> ADDI_WB.
  - ADDI_WB(12): reg_write, reg_dst=0, mem_to_reg=0. Completion.
  - Codes 13–15: unreachable; treated as IDLE (outputs 0, same transition).
- Completion state:
  - instr_count increments on the exit edge; wraps from 2^CNT_WIDTH-1 to 0.
  - Next state = FETCH if run, else IDLE.
  - run is ignored mid-instruction.
- Latency, FETCH entry to next FETCH/IDLE: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles.
- mem_read and mem_write are never both 1. pc_write is never asserted outside FETCH/BRANCH/JUMP.

Test Plan:
- Reset/run: rst_n=0 for 2 edges -> state_dbg=0, all outputs 0, instr_count=0. Set rst_n=1, run=1 -> next cycle state_dbg=1 with mem_read=ir_write=pc_write=1, alu_src_b=01, alu_sel=00.
- lw (opcode 0x23): state_dbg sequence 1,2,3,4,5,1.
  - State 4: mem_read=1, iord=1.
  - State 5: reg_write=1, mem_to_reg=1.
  - instr_count 0 -> 1 after state 5.
- R-type: opcode 0x00 with funct 0x22/0x24/0x25/0x20 -> EXECUTE alu_sel = 01/10/11/00 respectively; R_WB has reg_write=1, reg_dst=1.
- beq (opcode 0x04):
  - zero_flag=1 in state 9 -> pc_write=1, pc_source=01.
  - zero_flag=0 -> pc_write=0.
  - Both return to FETCH after 3 cycles.
- Illegal: opcode 0x3F, and opcode 0x00 with funct 0x00 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, instr_count unchanged.
- Reset mid-op and stop:
  - rst_n=0 during MEM_READ -> after the edge state_dbg=0, all outputs 0, count 0.
  - run=0 during R_WB -> next state IDLE, count incremented.
